// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path.
// Holds the frame-sequencer state encoding, the legal oversampling ratios
// and helpers that derive the bit-index constants from the data width.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    VALID  = 3'd5
  } rx_state_t;

  localparam int PRESCALE_8  = 8;
  localparam int PRESCALE_16 = 16;
  localparam int PRESCALE_32 = 32;

  localparam int BIT_CNT_W = 4;

  localparam logic [BIT_CNT_W-1:0] START_BIT = '0;

  // Index of the parity bit for a given data width.
  function automatic logic [BIT_CNT_W-1:0] par_bit(input int dw);
    return BIT_CNT_W'(dw + 1);
  endfunction

  // Index of the stop bit; it moves up by one when parity is present.
  function automatic logic [BIT_CNT_W-1:0] stp_bit(input int dw, input logic pe);
    return BIT_CNT_W'(dw + 1 + int'(pe));
  endfunction

endpackage

// File: rtl/edge_bit_counter.sv
// Oversample-edge and bit-position counter for the UART frame sequencer.
// Ports:
//   clk, rst        : clock, asynchronous active-low reset
//   clr_i           : return both counters to 0 (frame end / abort)
//   load_i          : start of frame; the detect cycle was edge 0, so edge -> 1
//   en_i            : count edges (frame in progress)
//   prescale_i      : latched oversampling ratio
//   edge_cnt_o      : oversample index within the current bit
//   bit_cnt_o       : bit index within the frame
//   last_edge_o     : high on the final oversample edge of the current bit
module edge_bit_counter
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_i,
  input  logic                  load_i,
  input  logic                  en_i,
  input  logic [PRESCALE_W-1:0] prescale_i,
  output logic [PRESCALE_W-1:0] edge_cnt_o,
  output logic [BIT_CNT_W-1:0]  bit_cnt_o,
  output logic                  last_edge_o
);

  localparam logic [PRESCALE_W-1:0] EDGE_ONE = PRESCALE_W'(1);
  localparam logic [BIT_CNT_W-1:0]  BIT_ONE  = BIT_CNT_W'(1);

  logic [PRESCALE_W-1:0] edge_q;
  logic [BIT_CNT_W-1:0]  bit_q;

  assign last_edge_o = en_i && (edge_q == (prescale_i - EDGE_ONE));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      edge_q <= '0;
      bit_q  <= '0;
    end else if (clr_i) begin
      edge_q <= '0;
      bit_q  <= '0;
    end else if (load_i) begin
      edge_q <= EDGE_ONE;
      bit_q  <= START_BIT;
    end else if (en_i) begin
      if (last_edge_o) begin
        edge_q <= '0;
        bit_q  <= bit_q + BIT_ONE;
      end else begin
        edge_q <= edge_q + EDGE_ONE;
      end
    end
  end

  assign edge_cnt_o = edge_q;
  assign bit_cnt_o  = bit_q;

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receive frame sequencer.
// Tracks oversample edges and bit position, enables the sampler,
// deserializer and start/parity/stop checkers, and reports the frame
// outcome as a one-cycle data_valid or frame_drop pulse.
// Ports:
//   clk, rst              : receiver clock (prescale x baud), async active-low reset
//   rx_in                 : synchronized serial line, idles high
//   prescale, par_en      : oversampling ratio and parity enable, latched at frame start
//   smpl_ready            : sampler strobe (sequencing is purely edge-counted)
//   strt_glitch, par_err,
//   stp_err               : checker results, honoured on the last edge of their bit
//   edge_cnt, bit_cnt     : current oversample index and bit index
//   dat_samp_en, deser_en,
//   strt_chk_en, par_chk_en,
//   stp_chk_en            : datapath enables decoded from state
//   data_valid            : one-cycle good-frame pulse
//   frame_drop            : one-cycle aborted-frame pulse
module uart_rx_fsm
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  par_en,
  input  logic                  smpl_ready,
  input  logic                  strt_glitch,
  input  logic                  par_err,
  input  logic                  stp_err,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [BIT_CNT_W-1:0]  bit_cnt,
  output logic                  dat_samp_en,
  output logic                  deser_en,
  output logic                  strt_chk_en,
  output logic                  par_chk_en,
  output logic                  stp_chk_en,
  output logic                  data_valid,
  output logic                  frame_drop
);

  localparam logic [BIT_CNT_W-1:0] LAST_DATA_BIT = BIT_CNT_W'(DATA_WIDTH);

  rx_state_t             state_q, state_d;
  logic [PRESCALE_W-1:0] prescale_q;
  logic                  par_en_q;
  logic                  frame_drop_q, frame_drop_d;

  logic cnt_clr, cnt_load, cnt_en, last_edge;

  // Bit timing is derived from edge counting alone; the sampler strobe
  // carries no information the sequencer needs.
  logic unused_smpl_ready;
  assign unused_smpl_ready = smpl_ready;

  edge_bit_counter #(
    .PRESCALE_W (PRESCALE_W)
  ) u_cnt (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (cnt_clr),
    .load_i      (cnt_load),
    .en_i        (cnt_en),
    .prescale_i  (prescale_q),
    .edge_cnt_o  (edge_cnt),
    .bit_cnt_o   (bit_cnt),
    .last_edge_o (last_edge)
  );

  assign cnt_en = (state_q == START) || (state_q == DATA) ||
                  (state_q == PARITY) || (state_q == STOP);

  always_comb begin
    state_d      = state_q;
    frame_drop_d = 1'b0;
    cnt_clr      = 1'b0;
    cnt_load     = 1'b0;
    unique case (state_q)
      // VALID doubles as edge 0 of the next bit time, so a falling edge
      // seen there starts the next frame without losing a cycle.
      IDLE, VALID: begin
        if (!rx_in) begin
          state_d  = START;
          cnt_load = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (last_edge) begin
          if (strt_glitch) begin
            state_d      = IDLE;
            frame_drop_d = 1'b1;
            cnt_clr      = 1'b1;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (last_edge && (bit_cnt == LAST_DATA_BIT)) begin
          state_d = par_en_q ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (last_edge) begin
          if (par_err) begin
            state_d      = IDLE;
            frame_drop_d = 1'b1;
            cnt_clr      = 1'b1;
          end else begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (last_edge) begin
          cnt_clr = 1'b1;
          if (stp_err) begin
            state_d      = IDLE;
            frame_drop_d = 1'b1;
          end else begin
            state_d = VALID;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_clr = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      prescale_q   <= '0;
      par_en_q     <= 1'b0;
      frame_drop_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_drop_q <= frame_drop_d;
      // Frame configuration is frozen for the whole frame.
      if (cnt_load) begin
        prescale_q <= prescale;
        par_en_q   <= par_en;
      end
    end
  end

  assign dat_samp_en = cnt_en;
  assign deser_en    = (state_q == DATA);
  assign strt_chk_en = (state_q == START);
  assign par_chk_en  = (state_q == PARITY);
  assign stp_chk_en  = (state_q == STOP);
  assign data_valid  = (state_q == VALID);
  assign frame_drop  = frame_drop_q;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Bench for uart_rx_fsm: table-driven frame vectors, hand-written
// back-to-back and mid-frame reset sequences, then randomized traffic
// compared cycle by cycle against an arithmetic frame model.
module tb_uart_rx_fsm;
  import uart_rx_pkg::*;

  localparam int DW = 8;
  localparam int PW = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rx_in = 1'b1;
  logic [PW-1:0] prescale = PW'(8);
  logic          par_en = 1'b0;
  logic          smpl_ready = 1'b0;
  logic          strt_glitch = 1'b0;
  logic          par_err = 1'b0;
  logic          stp_err = 1'b0;

  logic [PW-1:0] edge_cnt;
  logic [3:0]    bit_cnt;
  logic          dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en;
  logic          data_valid, frame_drop;

  int checks = 0;
  int errors = 0;

  uart_rx_fsm #(.DATA_WIDTH(DW), .PRESCALE_W(PW)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_in       (rx_in),
    .prescale    (prescale),
    .par_en      (par_en),
    .smpl_ready  (smpl_ready),
    .strt_glitch (strt_glitch),
    .par_err     (par_err),
    .stp_err     (stp_err),
    .edge_cnt    (edge_cnt),
    .bit_cnt     (bit_cnt),
    .dat_samp_en (dat_samp_en),
    .deser_en    (deser_en),
    .strt_chk_en (strt_chk_en),
    .par_chk_en  (par_chk_en),
    .stp_chk_en  (stp_chk_en),
    .data_valid  (data_valid),
    .frame_drop  (frame_drop)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference model: a frame is just an offset k from the detect cycle;
  // bit = k / p, edge = k % p, and the frame is (DW+2+pe)*p cycles long.
  typedef struct {
    int act;
    int k;
    int p;
    int pe;
    int valid;
    int drop;
  } mstate_t;

  mstate_t m;

  function automatic mstate_t m_next(input mstate_t s, input logic rxi,
                                     input int pin, input logic pein,
                                     input logic g, input logic pr, input logic sr);
    mstate_t n;
    int b, nb;
    logic lst, err;
    n = s;
    n.valid = 0;
    n.drop  = 0;
    if (s.act == 0) begin
      if (!rxi) begin
        n.act = 1; n.k = 1; n.p = pin; n.pe = int'(pein);
      end
    end else begin
      b   = s.k / s.p;
      nb  = DW + 2 + s.pe;
      lst = ((s.k % s.p) == s.p - 1);
      err = lst && ((b == 0 && g) || (s.pe != 0 && b == DW + 1 && pr) ||
                    (b == nb - 1 && sr));
      if (err) begin
        n.act = 0; n.drop = 1;
      end else if (s.k + 1 == nb * s.p) begin
        n.act = 0; n.valid = 1;
      end else begin
        n.k = s.k + 1;
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) m <= '{0, 0, 0, 0, 0, 0};
    else m <= m_next(m, rx_in, int'(prescale), par_en, strt_glitch, par_err, stp_err);
  end

  function automatic int exp_vec();
    int e, b;
    logic samp, des, sc, pc, sp;
    logic [16:0] v;
    e = 0; b = 0; samp = 0; des = 0; sc = 0; pc = 0; sp = 0;
    if (m.act != 0) begin
      e    = m.k % m.p;
      b    = m.k / m.p;
      samp = 1'b1;
      des  = (b >= 1 && b <= DW);
      sc   = (b == 0);
      pc   = (m.pe != 0 && b == DW + 1);
      sp   = !sc && !des && !pc;
    end
    v = {e[5:0], b[3:0], samp, des, sc, pc, sp, (m.valid != 0), (m.drop != 0)};
    return int'(v);
  endfunction

  function automatic int dut_vec();
    logic [16:0] v;
    v = {edge_cnt, bit_cnt, dat_samp_en, deser_en, strt_chk_en, par_chk_en,
         stp_chk_en, data_valid, frame_drop};
    return int'(v);
  endfunction

  // One frame vector: configuration, error inputs held for the frame,
  // rx_in low cycles, and the expected event cycles (-1 = never).
  typedef struct {
    int p; int pe; int g; int perr; int serr; int low;
    int valid_c; int drop_c; int dfirst; int dlast; int pfirst;
  } vec_t;

  vec_t tbl[8];

  task automatic run_vec(input string nm, input vec_t v);
    int vfirst, vcnt, dfirst, dcnt, defirst, delast, pfirst, endc;
    vfirst = -1; vcnt = 0; dfirst = -1; dcnt = 0; defirst = -1; delast = -1; pfirst = -1;
    endc = ((v.valid_c > v.drop_c) ? v.valid_c : v.drop_c) + 4;
    rx_in = 1'b1;
    prescale = PW'(v.p); par_en = (v.pe != 0);
    strt_glitch = (v.g != 0); par_err = (v.perr != 0); stp_err = (v.serr != 0);
    repeat (3) @(negedge clk);
    rx_in = 1'b0;
    for (int c = 1; c <= endc; c++) begin
      @(negedge clk);
      if (c == 1) check({nm, "_edge1"}, int'(edge_cnt), 1);
      if (c >= v.low) rx_in = 1'b1;
      if (c == 3) begin
        // Configuration changes mid-frame must be ignored.
        prescale = (v.p == 32) ? PW'(8) : PW'(32);
        par_en = (v.pe == 0);
      end
      if (data_valid) begin vcnt++; if (vfirst < 0) vfirst = c; end
      if (frame_drop) begin
        dcnt++;
        if (dfirst < 0) begin
          dfirst = c;
          check({nm, "_drop_bitcnt"}, int'(bit_cnt), int'(START_BIT));
          check({nm, "_drop_idle"}, int'(dat_samp_en), 0);
        end
      end
      if (deser_en) begin if (defirst < 0) defirst = c; delast = c; end
      if (par_chk_en && pfirst < 0) pfirst = c;
    end
    check({nm, "_valid_cyc"}, vfirst, v.valid_c);
    check({nm, "_valid_cnt"}, vcnt, (v.valid_c >= 0) ? 1 : 0);
    check({nm, "_drop_cyc"}, dfirst, v.drop_c);
    check({nm, "_drop_cnt"}, dcnt, (v.drop_c >= 0) ? 1 : 0);
    check({nm, "_deser_first"}, defirst, v.dfirst);
    check({nm, "_deser_last"}, delast, v.dlast);
    check({nm, "_par_first"}, pfirst, v.pfirst);
    strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
  endtask

  initial begin
    int first, second;
    //            p  pe g perr serr low valid drop dfirst dlast pfirst
    tbl[0] = '{8,  0, 0, 0, 0, 1,  80,  -1,  8,  71,  -1};  // 8N1 p8 clean
    tbl[1] = '{16, 1, 0, 1, 0, 1,  -1, 160, 16, 143, 144};  // 8E1 parity error
    tbl[2] = '{8,  0, 1, 0, 0, 2,  -1,   8, -1,  -1,  -1};  // start glitch
    tbl[3] = '{8,  0, 0, 0, 1, 1,  -1,  80,  8,  71,  -1};  // stop error 8N1
    tbl[4] = '{16, 1, 0, 0, 0, 1, 176,  -1, 16, 143, 144};  // 8E1 p16 clean
    tbl[5] = '{32, 0, 0, 0, 0, 1, 320,  -1, 32, 287,  -1};  // 8N1 p32 clean
    tbl[6] = '{8,  0, 0, 1, 0, 1,  80,  -1,  8,  71,  -1};  // par_err ignored without parity
    tbl[7] = '{8,  1, 0, 0, 1, 1,  -1,  88,  8,  71,  72};  // stop error with parity

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_outputs", dut_vec(), 0);
    rst = 1'b1;
    @(negedge clk);
    check("idle_outputs", dut_vec(), 0);

    for (int i = 0; i < 8; i++) run_vec($sformatf("vec%0d", i), tbl[i]);

    // Back-to-back frames at prescale 32 with rx_in low during VALID
    prescale = PW'(PRESCALE_32); par_en = 1'b0;
    repeat (3) @(negedge clk);
    rx_in = 1'b0;
    first = -1; second = -1;
    for (int c = 1; c <= 700 && second < 0; c++) begin
      @(negedge clk);
      if (c == 1) rx_in = 1'b1;
      if (data_valid) begin
        if (first < 0) begin first = c; rx_in = 1'b0; end
        else second = c;
      end else if (first >= 0 && c == first + 1) begin
        check("b2b_edge1", int'(edge_cnt), 1);
        check("b2b_start", int'(strt_chk_en), 1);
        rx_in = 1'b1;
      end
    end
    check("b2b_first", first, 320);
    check("b2b_gap", (second < 0) ? -1 : second - first, 320);

    // Reset asserted in the middle of an active frame
    prescale = PW'(PRESCALE_8); par_en = 1'b0;
    repeat (3) @(negedge clk);
    rx_in = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) rx_in = 1'b1;
    end
    check("midreset_pre_bitcnt", int'(bit_cnt), 5);
    rst = 1'b0;
    #1;
    check("midreset_async", dut_vec(), 0);
    repeat (3) @(negedge clk);
    check("midreset_hold", dut_vec(), 0);
    rst = 1'b1;
    run_vec("after_reset", tbl[0]);

    // Randomized traffic against the model
    for (int c = 0; c < 8000; c++) begin
      @(negedge clk);
      check("rand", dut_vec(), exp_vec());
      rx_in = ($urandom % 4) != 0;
      case ($urandom % 3)
        0: prescale = PW'(PRESCALE_8);
        1: prescale = PW'(PRESCALE_16);
        default: prescale = PW'(PRESCALE_32);
      endcase
      par_en      = $urandom % 2;
      smpl_ready  = $urandom % 2;
      strt_glitch = ($urandom % 12) == 0;
      par_err     = ($urandom % 12) == 0;
      stp_err     = ($urandom % 12) == 0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
